// File: rtl/scan_sequencer.sv
// scan_sequencer: steps a 2-bit select through the 4 outputs of the 2-to-4
// decoder with a programmable dwell (div+1 cycles) and a fixed blanking gap.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   start  level; leaves IDLE and begins scanning from index 0
//   stop   level; forces IDLE from any state (wins over start)
//   dir    0 = count up, 1 = count down (sampled at each advance)
//   div    dwell length, SHOW lasts div+1 cycles (captured on SHOW entry)
//   e      decoder enable (registered)
//   x0,x1  decoder select bits (registered)
//   wrap   one-cycle pulse when a new index 0 (up) or 3 (down) is presented
//   busy   high in SHOW and BLANK
module scan_sequencer #(
  parameter int DIV_W = 8,
  parameter int BLANK = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             dir,
  input  logic [DIV_W-1:0] div,
  output logic             e,
  output logic             x0,
  output logic             x1,
  output logic             wrap,
  output logic             busy
);

  localparam int BW =
    (BLANK > 0) ? $clog2(BLANK + 1) : 1;
  localparam int CNT_W =
    (DIV_W > BW) ? DIV_W : BW;
  localparam int BL =
    (BLANK > 0) ? BLANK - 1 : 0;
  localparam logic [CNT_W-1:0] BLANK_LD =
    CNT_W'(BL);
  localparam logic HAS_BLANK = (BLANK > 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHOW,
    S_BLANK
  } state_t;

  state_t           state;
  logic [1:0]       idx;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] div_ld;
  logic [1:0]       idx_nxt;
  logic             wrap_nxt;

  // The counter register doubles as the captured dwell length: it is
  // loaded from div only on SHOW entry, so later div changes are ignored.
  assign div_ld = CNT_W'(div);

  assign idx_nxt  = dir ? idx - 2'd1 : idx + 2'd1;
  assign wrap_nxt = dir ? (idx == 2'd0)
                        : (idx == 2'd3);

  assign x0 = idx[0];
  assign x1 = idx[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      idx   <= 2'd0;
      cnt   <= '0;
      e     <= 1'b0;
      wrap  <= 1'b0;
      busy  <= 1'b0;
    end else if (stop) begin
      state <= S_IDLE;
      idx   <= 2'd0;
      cnt   <= '0;
      e     <= 1'b0;
      wrap  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      wrap <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_SHOW;
            idx   <= 2'd0;
            cnt   <= div_ld;
            e     <= 1'b1;
            busy  <= 1'b1;
          end
        end
        S_SHOW: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (HAS_BLANK) begin
            // select bits hold while e drops,
            // so the decoder never sees a glitch
            state <= S_BLANK;
            e     <= 1'b0;
            cnt   <= BLANK_LD;
          end else begin
            idx  <= idx_nxt;
            wrap <= wrap_nxt;
            cnt  <= div_ld;
          end
        end
        S_BLANK: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            state <= S_SHOW;
            idx   <= idx_nxt;
            wrap  <= wrap_nxt;
            cnt   <= div_ld;
            e     <= 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          idx   <= 2'd0;
          cnt   <= '0;
          e     <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_scan_sequencer.sv
// tb_scan_sequencer: directed checks of scan_sequencer with BLANK=2
// (instance dut) and BLANK=0 (instance dut0).
module tb_scan_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       dir = 1'b0;
  logic [7:0] div = 8'd0;
  logic       e, x0, x1, wrap, busy;

  logic       start0 = 1'b0;
  logic       stop0 = 1'b0;
  logic       dir0 = 1'b0;
  logic [7:0] div0 = 8'd0;
  logic       e0, x00, x10, wrap0, busy0;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  scan_sequencer #(.DIV_W(8), .BLANK(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .start(start), .stop(stop),
    .dir(dir), .div(div),
    .e(e), .x0(x0), .x1(x1),
    .wrap(wrap), .busy(busy)
  );

  scan_sequencer #(.DIV_W(8), .BLANK(0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .start(start0), .stop(stop0),
    .dir(dir0), .div(div0),
    .e(e0), .x0(x00), .x1(x10),
    .wrap(wrap0), .busy(busy0)
  );

  // observation word: {busy, wrap, e, x1, x0}
  function automatic logic [4:0] obs();
    return {busy, wrap, e, x1, x0};
  endfunction

  function automatic logic [4:0] obs0();
    return {busy0, wrap0, e0, x10, x00};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [4:0] o,
                     input logic [4:0] x);
    n_cmp++;
    assert (o === x) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b",
             tag, o, x);
    end
  endtask

  task automatic run(input int n,
                     input logic [4:0] x,
                     input string tag);
    for (int i = 0; i < n; i++) begin
      tick();
      chk(tag, obs(), x);
    end
  endtask

  initial begin
    logic       pe;
    logic [1:0] pidx;
    int         t;

    // reset state
    #2 rst_n = 1'b0;
    #1 chk("rst_async", obs(), 5'b00000);
    chk("rst_async0", obs0(), 5'b00000);
    tick();
    tick();
    rst_n = 1'b1;
    run(1, 5'b00000, "idle_after_rst");

    // up scan: div=3, BLANK=2
    div = 8'd3;
    dir = 1'b0;
    start = 1'b1;
    run(1, 5'b10100, "up_start");
    start = 1'b0;
    run(3, 5'b10100, "up_show0");
    run(2, 5'b10000, "up_blank0");
    run(4, 5'b10101, "up_show1");
    run(2, 5'b10001, "up_blank1");
    run(4, 5'b10110, "up_show2");
    run(2, 5'b10010, "up_blank2");
    run(4, 5'b10111, "up_show3");
    run(2, 5'b10011, "up_blank3");
    run(1, 5'b11100, "up_wrap");
    run(3, 5'b10100, "up_show0b");
    run(2, 5'b10000, "up_blank0b");

    // div change mid-slot, dir change during BLANK
    run(1, 5'b10101, "mid_show1_entry");
    div = 8'd1;
    run(3, 5'b10101, "mid_show1_keep");
    run(2, 5'b10001, "mid_blank1");
    run(2, 5'b10110, "mid_show2_short");
    run(1, 5'b10010, "mid_blank2a");
    dir = 1'b1;
    run(1, 5'b10010, "mid_blank2b");
    run(2, 5'b10101, "dn_show1");
    run(2, 5'b10001, "dn_blank1");
    run(1, 5'b10100, "dn_show0_nowrap");
    run(1, 5'b10100, "dn_show0");
    run(2, 5'b10000, "dn_blank0");
    run(1, 5'b11111, "dn_wrap3");
    run(1, 5'b10111, "dn_show3");
    run(1, 5'b10011, "dn_blank3");

    // stop during BLANK at idx 3
    stop = 1'b1;
    run(1, 5'b00000, "stop_blank3");
    start = 1'b1;
    run(2, 5'b00000, "start_stop_both");
    stop = 1'b0;
    dir = 1'b0;
    run(1, 5'b10100, "restart_held");
    start = 1'b0;

    // glitch check: random dwell, BLANK=2
    stop = 1'b1;
    tick();
    stop = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 800; i++) begin
      div = 8'($urandom_range(0, 7));
      pe = e;
      pidx = {x1, x0};
      tick();
      if (pe && e) begin
        chk("glitch_sel", {3'b000, x1, x0},
            {3'b000, pidx});
      end
    end
    stop = 1'b1;
    run(1, 5'b00000, "glitch_stop");
    stop = 1'b0;

    // down scan: div=0, BLANK=0
    div0 = 8'd0;
    dir0 = 1'b1;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    chk("dn0_start", obs0(), 5'b10100);
    for (t = 1; t <= 12; t++) begin
      tick();
      chk("dn0_seq", obs0(),
          {1'b1, (t % 4 == 1), 1'b1,
           2'((4 - (t % 4)) % 4)});
    end
    stop0 = 1'b1;
    tick();
    chk("dn0_stop", obs0(), 5'b00000);
    stop0 = 1'b0;

    // reset mid-SHOW at idx 2 (div=0, BLANK=2)
    div = 8'd0;
    dir = 1'b0;
    start = 1'b1;
    run(1, 5'b10100, "r_show0");
    start = 1'b0;
    run(2, 5'b10000, "r_blank0");
    run(1, 5'b10101, "r_show1");
    run(2, 5'b10001, "r_blank1");
    run(1, 5'b10110, "r_show2");
    #1 rst_n = 1'b0;
    #1 chk("rst_mid_show", obs(), 5'b00000);
    tick();
    rst_n = 1'b1;
    run(2, 5'b00000, "rst_idle");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
